// File: rtl/rvv_result_packer_pkg.sv
// Shared types and helpers for the vector result packer.
package rvv_result_packer_pkg;

  // Element width codes
  localparam logic [2:0] SewE8  = 3'd0;
  localparam logic [2:0] SewE16 = 3'd1;
  localparam logic [2:0] SewE32 = 3'd2;
  localparam logic [2:0] SewE64 = 3'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite
  } state_e;

  // Operation configuration latched on start
  typedef struct packed {
    logic [4:0]  vd;
    logic [2:0]  vsew;
    logic [16:0] vl;
    logic        mask_op;
    logic        red_op;
  } op_cfg_t;

  // Element width in bits; reserved codes saturate to 64.
  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    case (vsew)
      SewE8:   return 8;
      SewE16:  return 16;
      SewE32:  return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned byte_count(input int unsigned bits);
    return bits / 8;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rvv_result_packer_lane_merge.sv
// Per-lane placement: computes the destination bit enables, positioned data
// and byte enables for one lane result.
module rvv_lane_merge
  import rvv_result_packer_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter int unsigned LANE_IDX   = 0
) (
  input  logic [2:0]        vsew_i,
  input  logic [16:0]       vl_i,
  input  logic              mask_op_i,
  input  logic              red_op_i,
  input  logic              res_i,
  input  logic [16:0]       regi_i,
  input  logic [3:0]        chunk_off_i,
  input  logic [63:0]       slot_i,
  output logic [VLEN-1:0]   bit_en_o,
  output logic [VLEN-1:0]   data_o,
  output logic [VLEN/8-1:0] be_o
);

  int unsigned sew;
  int unsigned lw;
  int unsigned w;
  int unsigned off;
  logic        hit;
  logic [63:0] fmask;

  // Decide whether this lane writes, and where / how wide
  always_comb begin
    sew = sew_bits(vsew_i);
    lw  = 32'd1 << LANE_WIDTH;
    hit = 1'b0;
    w   = 0;
    off = 0;
    if (res_i) begin
      if (red_op_i) begin
        // Scalar result always lands in element 0 from lane 0 only
        hit = (LANE_IDX == 0) && (vl_i != 17'd0);
        w   = sew;
        off = 0;
      end else if (mask_op_i) begin
        hit = (32'(regi_i) < 32'(vl_i)) && (32'(regi_i) < VLEN);
        w   = 1;
        off = 32'(regi_i);
      end else begin
        w   = min_u(sew, lw);
        hit = (32'(regi_i) < 32'(vl_i)) && (32'(regi_i) < VLEN / sew);
        if (sew > lw) begin
          // Element wider than the lane: place this chunk inside the element
          hit = hit && (32'(chunk_off_i) * lw < sew);
          off = 32'(regi_i) * sew + 32'(chunk_off_i) * lw;
        end else begin
          off = 32'(regi_i) * sew;
        end
      end
    end
    fmask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (!hit) fmask = '0;
    bit_en_o = VLEN'(fmask) << off;
    data_o   = VLEN'(slot_i & fmask) << off;
  end

  // Byte enables cover every touched byte; mask ops set theirs at op end
  always_comb begin
    be_o = '0;
    if (!mask_op_i) begin
      for (int b = 0; b < VLEN / 8; b++) be_o[b] = |bit_en_o[8*b +: 8];
    end
  end

endmodule

// File: rtl/rvv_result_packer.sv
// Vector writeback packer: merges lane results into a VLEN buffer and issues
// one register-file write per operation.
module rvv_result_packer
  import rvv_result_packer_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter int unsigned NB_LANES   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [4:0]                  vd_index_i,
  input  logic [2:0]                  vsew_i,
  input  logic [16:0]                 vl_i,
  input  logic                        instr_mask_i,
  input  logic                        is_reduction_i,
  input  logic [(1<<NB_LANES)-1:0]    res_i,
  input  logic [(17<<NB_LANES)-1:0]   regi_i,
  input  logic [3:0]                  chunk_off_i,
  input  logic [(64<<NB_LANES)-1:0]   vd_i,
  input  logic                        alu_done_i,
  output logic                        busy_o,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [4:0]                  wb_index_o,
  output logic [VLEN-1:0]             wb_data_o,
  output logic [byte_count(VLEN)-1:0] wb_be_o
);

  localparam int unsigned NLanes = 1 << NB_LANES;
  localparam int unsigned VBytes = byte_count(VLEN);

  state_e            state_q, state_d;
  op_cfg_t           cfg_q, cfg_d;
  logic [VLEN-1:0]   buf_q, buf_d;
  logic [VBytes-1:0] be_q, be_d;

  logic [VLEN-1:0]   lane_bit  [NLanes];
  logic [VLEN-1:0]   lane_data [NLanes];
  logic [VBytes-1:0] lane_be   [NLanes];

  for (genvar i = 0; i < NLanes; i++) begin : g_lane
    rvv_lane_merge #(
      .VLEN       (VLEN),
      .LANE_WIDTH (LANE_WIDTH),
      .LANE_IDX   (i)
    ) u_merge (
      .vsew_i      (cfg_q.vsew),
      .vl_i        (cfg_q.vl),
      .mask_op_i   (cfg_q.mask_op),
      .red_op_i    (cfg_q.red_op),
      .res_i       (res_i[i]),
      .regi_i      (regi_i[17*i +: 17]),
      .chunk_off_i (chunk_off_i),
      .slot_i      (vd_i[64*i +: 64]),
      .bit_en_o    (lane_bit[i]),
      .data_o      (lane_data[i]),
      .be_o        (lane_be[i])
    );
  end

  // Next-state: FSM, config latch and buffer merge
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    buf_d   = buf_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d       = StCollect;
          cfg_d.vd      = vd_index_i;
          cfg_d.vsew    = vsew_i;
          cfg_d.vl      = vl_i;
          cfg_d.mask_op = instr_mask_i;
          cfg_d.red_op  = is_reduction_i;
          buf_d         = '0;
          be_d          = '0;
        end
      end
      StCollect: begin
        // Ascending lane order so the higher lane wins on overlap
        for (int i = 0; i < NLanes; i++) begin
          buf_d = (buf_d & ~lane_bit[i]) | (lane_data[i] & lane_bit[i]);
          be_d  = be_d | lane_be[i];
        end
        if (alu_done_i) begin
          state_d = StWrite;
          if (cfg_q.mask_op) begin
            for (int b = 0; b < VBytes; b++) be_d[b] = (32'(b) * 32'd8) < 32'(cfg_q.vl);
          end
        end
      end
      StWrite: begin
        if (wb_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      buf_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      buf_q   <= buf_d;
      be_q    <= be_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    busy_o     = (state_q != StIdle);
    wb_valid_o = (state_q == StWrite);
    wb_index_o = cfg_q.vd;
    wb_data_o  = buf_q;
    wb_be_o    = be_q;
  end

endmodule

// File: tb/tb_rvv_result_packer.sv
// Directed self-checking bench for rvv_result_packer (VLEN=128, 2 lanes, L=8).
module tb_rvv_result_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   vd_index;
  logic [2:0]   vsew;
  logic [16:0]  vl;
  logic         instr_mask;
  logic         is_reduction;
  logic [1:0]   res;
  logic [33:0]  regi;
  logic [3:0]   chunk_off;
  logic [127:0] vd;
  logic         alu_done;
  logic         busy;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_index;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rvv_result_packer #(
    .VLEN       (128),
    .LANE_WIDTH (3),
    .NB_LANES   (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .vd_index_i     (vd_index),
    .vsew_i         (vsew),
    .vl_i           (vl),
    .instr_mask_i   (instr_mask),
    .is_reduction_i (is_reduction),
    .res_i          (res),
    .regi_i         (regi),
    .chunk_off_i    (chunk_off),
    .vd_i           (vd),
    .alu_done_i     (alu_done),
    .busy_o         (busy),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_index_o     (wb_index),
    .wb_data_o      (wb_data),
    .wb_be_o        (wb_be)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [4:0] d, input logic [2:0] s, input logic [16:0] l,
                          input logic m, input logic r);
    vd_index = d; vsew = s; vl = l; instr_mask = m; is_reduction = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] r, input logic [16:0] i0, input logic [16:0] i1,
                      input logic [3:0] c, input logic [63:0] s0, input logic [63:0] s1,
                      input logic d);
    res = r; regi = {i1, i0}; chunk_off = c; vd = {s1, s0}; alu_done = d;
    tick();
    res = '0; alu_done = 1'b0;
  endtask

  task automatic finish_write;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    n_checks++; if (wb_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", wb_valid); n_fail++; end
    n_checks++; if (wb_index !== 5'd0) begin $display("FAIL reset_index got %h want 0", wb_index); n_fail++; end
    n_checks++; if (wb_data !== 128'd0) begin $display("FAIL reset_data got %h want 0", wb_data); n_fail++; end
    n_checks++; if (wb_be !== 16'd0) begin $display("FAIL reset_be got %h want 0", wb_be); n_fail++; end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sew8;
    start_op(5'd3, 3'd0, 17'd16, 1'b0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin $display("FAIL sew8_busy got %b want 1", busy); n_fail++; end
    for (int k = 0; k < 8; k++) begin
      beat(2'b11, 17'(2*k), 17'(2*k+1), 4'd0, 64'(2*k + 'h10), 64'(2*k + 1 + 'h10), k == 7);
    end
    n_checks++; if (wb_valid !== 1'b1) begin $display("FAIL sew8_latency got %b want 1", wb_valid); n_fail++; end
    n_checks++;
    if (wb_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      $display("FAIL sew8_data got %h want 1f1e1d1c1b1a19181716151413121110", wb_data); n_fail++;
    end
    n_checks++; if (wb_be !== 16'hFFFF) begin $display("FAIL sew8_be got %h want ffff", wb_be); n_fail++; end
    n_checks++; if (wb_index !== 5'd3) begin $display("FAIL sew8_index got %0d want 3", wb_index); n_fail++; end
    finish_write();
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL sew8_done got valid=%b busy=%b want 0/0", wb_valid, busy); n_fail++;
    end
  endtask

  task automatic test_sew32_chunks;
    logic [63:0] a [4];
    logic [63:0] b [4];
    a[0] = 64'hAA; a[1] = 64'hBB; a[2] = 64'hCC; a[3] = 64'hDD;
    b[0] = 64'h11; b[1] = 64'h22; b[2] = 64'h33; b[3] = 64'h44;
    start_op(5'd4, 3'd2, 17'd2, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) beat(2'b11, 17'd0, 17'd1, 4'(c), a[c], b[c], 1'b0);
    // Element 2 is beyond vl and must be dropped
    beat(2'b10, 17'd0, 17'd2, 4'd0, 64'h0, 64'hEE, 1'b1);
    n_checks++;
    if (wb_data !== 128'h00000000_00000000_44332211_DDCCBBAA) begin
      $display("FAIL sew32_data got %h want 44332211ddccbbaa", wb_data); n_fail++;
    end
    n_checks++; if (wb_be !== 16'h00FF) begin $display("FAIL sew32_be got %h want 00ff", wb_be); n_fail++; end
    finish_write();
  endtask

  task automatic test_mask;
    start_op(5'd1, 3'd0, 17'd10, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) beat(2'b11, 17'(2*k), 17'(2*k+1), 4'd0, 64'hFF, 64'hFE, 1'b0);
    // Bits 10 and 11 are past vl
    beat(2'b11, 17'd10, 17'd11, 4'd0, 64'h1, 64'h1, 1'b1);
    n_checks++; if (wb_data !== 128'h155) begin $display("FAIL mask_data got %h want 155", wb_data); n_fail++; end
    n_checks++; if (wb_be !== 16'h0003) begin $display("FAIL mask_be got %h want 0003", wb_be); n_fail++; end
    finish_write();
  endtask

  task automatic test_reduction;
    start_op(5'd2, 3'd2, 17'd4, 1'b0, 1'b1);
    beat(2'b11, 17'd0, 17'd1, 4'd0, 64'hABCD_EF01_1234_5678, 64'h99, 1'b1);
    n_checks++; if (wb_data !== 128'h12345678) begin $display("FAIL red_data got %h want 12345678", wb_data); n_fail++; end
    n_checks++; if (wb_be !== 16'h000F) begin $display("FAIL red_be got %h want 000f", wb_be); n_fail++; end
    finish_write();
  endtask

  task automatic test_vl_zero;
    start_op(5'd6, 3'd0, 17'd0, 1'b0, 1'b0);
    beat(2'b11, 17'd0, 17'd1, 4'd0, 64'h5A, 64'hA5, 1'b1);
    n_checks++; if (wb_valid !== 1'b1) begin $display("FAIL vl0_valid got %b want 1", wb_valid); n_fail++; end
    n_checks++; if (wb_be !== 16'h0) begin $display("FAIL vl0_be got %h want 0000", wb_be); n_fail++; end
    n_checks++; if (wb_data !== 128'h0) begin $display("FAIL vl0_data got %h want 0", wb_data); n_fail++; end
    finish_write();
  endtask

  task automatic test_stall;
    start_op(5'd9, 3'd3, 17'd1, 1'b0, 1'b1);
    beat(2'b01, 17'd0, 17'd0, 4'd0, 64'hCAFEF00D_DEADBEEF, 64'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      // Junk during WRITE: a new start, results and alu_done must all be ignored
      start = (k == 1); vd_index = 5'd17; vsew = 3'd0; vl = 17'd16; is_reduction = 1'b0;
      res = 2'b11; regi = '0; vd = '1; alu_done = 1'b1;
      tick();
      start = 1'b0; res = '0; alu_done = 1'b0;
      n_checks++;
      if (wb_valid !== 1'b1 || busy !== 1'b1 || wb_index !== 5'd9) begin
        $display("FAIL stall_ctl cyc %0d got valid=%b busy=%b idx=%0d want 1/1/9",
                 k, wb_valid, busy, wb_index);
        n_fail++;
      end
      n_checks++;
      if (wb_data !== 128'hCAFEF00D_DEADBEEF || wb_be !== 16'h00FF) begin
        $display("FAIL stall_data cyc %0d got %h be %h want cafef00ddeadbeef be 00ff",
                 k, wb_data, wb_be);
        n_fail++;
      end
    end
    finish_write();
    n_checks++; if (busy !== 1'b0) begin $display("FAIL stall_idle got busy=%b want 0", busy); n_fail++; end
  endtask

  task automatic test_reset_mid;
    start_op(5'd5, 3'd0, 17'd16, 1'b0, 1'b0);
    beat(2'b11, 17'd0, 17'd1, 4'd0, 64'h55, 64'h66, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_index !== 5'd0 || wb_data !== 128'd0 ||
        wb_be !== 16'd0) begin
      $display("FAIL midrst_outs got busy=%b valid=%b idx=%0d data=%h be=%h want all 0",
               busy, wb_valid, wb_index, wb_data, wb_be);
      n_fail++;
    end
    #1 rst = 1'b0;
    tick();
    start_op(5'd8, 3'd0, 17'd4, 1'b0, 1'b0);
    // Both lanes target element 2: lane 1 must win
    beat(2'b11, 17'd2, 17'd2, 4'd0, 64'h11, 64'h77, 1'b0);
    beat(2'b01, 17'd3, 17'd0, 4'd0, 64'h88, 64'h0, 1'b1);
    n_checks++; if (wb_data !== 128'h88770000) begin $display("FAIL midrst_data got %h want 88770000", wb_data); n_fail++; end
    n_checks++; if (wb_be !== 16'h000C) begin $display("FAIL midrst_be got %h want 000c", wb_be); n_fail++; end
    n_checks++; if (wb_index !== 5'd8) begin $display("FAIL midrst_index got %0d want 8", wb_index); n_fail++; end
    finish_write();
  endtask

  initial begin
    start = 1'b0; vd_index = '0; vsew = '0; vl = '0; instr_mask = 1'b0; is_reduction = 1'b0;
    res = '0; regi = '0; chunk_off = '0; vd = '0; alu_done = 1'b0; wb_ready = 1'b0;
    test_reset();
    test_sew8();
    test_sew32_chunks();
    test_mask();
    test_reduction();
    test_vl_zero();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
